// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: CPU load/store/fetch vs video read-only fetch.
// Define ARB_ROUND_ROBIN_EN for strict alternation on ties instead of CPU priority.
module mem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } ownerT;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starveCnt;
    logic [3:0] starveCntNext;
    ownerT      rdOwner;
    ownerT      rdOwnerNext;
    logic       vidFirst;

`ifdef ARB_ROUND_ROBIN_EN
    ownerT      lastOwner;
    ownerT      lastOwnerNext;
`endif

    // Tie-break: which requester wins when both ask in the same cycle
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        vidFirst = (lastOwner == OWN_CPU);
`else
        vidFirst = (starveCnt == STARVE_LIM);
`endif
    end

    always_comb begin
        cpu_gnt = 1'b0;
        vid_gnt = 1'b0;
        unique case (1'b1)
            (cpu_req && !vid_req): cpu_gnt = 1'b1;
            (vid_req && !cpu_req): vid_gnt = 1'b1;
            (cpu_req && vid_req): begin
                cpu_gnt = !vidFirst;
                vid_gnt = vidFirst;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_addr  = vid_gnt ? vid_addr : cpu_addr;
        mem_we    = cpu_gnt & cpu_we;
        mem_wdata = cpu_wdata;
    end

    always_comb begin
        starveCntNext = 4'd0;
        if (vid_req && !vid_gnt) begin
            if (starveCnt == STARVE_LIM) begin
                starveCntNext = starveCnt;
            end else begin
                starveCntNext = starveCnt + 4'd1;
            end
        end
    end

    // Writes return nothing, so only read grants claim the return slot
    always_comb begin
        rdOwnerNext = OWN_NONE;
        unique case (1'b1)
            (cpu_gnt && !cpu_we): rdOwnerNext = OWN_CPU;
            vid_gnt:              rdOwnerNext = OWN_VID;
            default:              rdOwnerNext = OWN_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starveCnt <= 4'd0;
            rdOwner   <= OWN_NONE;
        end else begin
            starveCnt <= starveCntNext;
            rdOwner   <= rdOwnerNext;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        lastOwnerNext = lastOwner;
        unique case (1'b1)
            cpu_gnt: lastOwnerNext = OWN_CPU;
            vid_gnt: lastOwnerNext = OWN_VID;
            default: lastOwnerNext = lastOwner;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastOwner <= OWN_VID;
        end else begin
            lastOwner <= lastOwnerNext;
        end
    end
`endif

    assign cpu_rvalid = (rdOwner == OWN_CPU);
    assign vid_rvalid = (rdOwner == OWN_VID);
    assign cpu_rdata  = mem_q;
    assign vid_rdata  = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [9:0]  cpu_addr = 10'h000;
    logic [15:0] cpu_wdata = 16'h0000;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        vid_req = 1'b0;
    logic [9:0]  vid_addr = 10'h000;
    logic        vid_gnt;
    logic        vid_rvalid;
    logic [15:0] vid_rdata;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_q = 16'h0000;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W(10),
        .DATA_W(16),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .vid_req(vid_req),
        .vid_addr(vid_addr),
        .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid),
        .vid_rdata(vid_rdata),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        cpu_req = 1'b0;
        vid_req = 1'b0;
        cpu_we = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cpu_addr = 10'h2A5;
        cpu_wdata = 16'hA5A5;
        vid_addr = 10'h111;
        step();
        checks++;
        if (cpu_rvalid !== 1'b0 || vid_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rvalid got %b%b want 00", cpu_rvalid, vid_rvalid);
        end
        rst = 1'b1;
        step();
        checks++;
        if (cpu_gnt !== 1'b0 || vid_gnt !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_gnt got %b%b%b want 000", cpu_gnt, vid_gnt, mem_we);
        end
        checks++;
        if (mem_addr !== 10'h2A5 || mem_wdata !== 16'hA5A5) begin
            errors++;
            $display("FAIL idle_mux got %h/%h want 2a5/a5a5", mem_addr, mem_wdata);
        end
        step();
        checks++;
        if (cpu_rvalid !== 1'b0 || vid_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_rvalid got %b%b want 00", cpu_rvalid, vid_rvalid);
        end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 10'h012;
        #1;
        checks++;
        if (cpu_gnt !== 1'b1 || vid_gnt !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rd_gnt got %b%b%b want 100", cpu_gnt, vid_gnt, mem_we);
        end
        checks++;
        if (mem_addr !== 10'h012) begin
            errors++;
            $display("FAIL rd_addr got %h want 012", mem_addr);
        end
        step();
        cpu_req = 1'b0;
        mem_q = 16'hBEEF;
        #1;
        checks++;
        if (cpu_rvalid !== 1'b1 || vid_rvalid !== 1'b0 || cpu_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_ret got %b%b %h want 10 beef", cpu_rvalid, vid_rvalid, cpu_rdata);
        end
        step();
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_once got %b want 0", cpu_rvalid);
        end
    endtask

    task automatic test_arbitration();
        logic expVid;
        logic prevVid;
        doReset();
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 10'h0AA;
        vid_req = 1'b1;
        vid_addr = 10'h155;
        prevVid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            expVid = (c % 2) == 1;
`else
            expVid = (c % 5) == 4;
`endif
            checks++;
            if (vid_gnt !== expVid || cpu_gnt !== !expVid) begin
                errors++;
                $display("FAIL arb_gnt c=%0d got %b%b want %b%b", c, cpu_gnt, vid_gnt, !expVid, expVid);
            end
            checks++;
            if (mem_addr !== (expVid ? 10'h155 : 10'h0AA)) begin
                errors++;
                $display("FAIL arb_addr c=%0d got %h", c, mem_addr);
            end
            step();
            checks++;
            if (vid_rvalid !== expVid || cpu_rvalid !== !expVid) begin
                errors++;
                $display("FAIL arb_rvalid c=%0d got %b%b want %b%b", c, cpu_rvalid, vid_rvalid, !expVid, expVid);
            end
            prevVid = expVid;
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
        step();
        checks++;
        if (cpu_rvalid !== 1'b0 || vid_rvalid !== 1'b0 || prevVid !== 1'b1) begin
            errors++;
            $display("FAIL arb_idle got %b%b", cpu_rvalid, vid_rvalid);
        end
    endtask

    task automatic test_write_vs_vid();
        doReset();
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 10'h3FF;
        cpu_wdata = 16'h1234;
        vid_req = 1'b1;
        vid_addr = 10'h001;
        #1;
        checks++;
        if (cpu_gnt !== 1'b1 || vid_gnt !== 1'b0 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL wr_gnt got %b%b%b want 101", cpu_gnt, vid_gnt, mem_we);
        end
        checks++;
        if (mem_addr !== 10'h3FF || mem_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL wr_bus got %h/%h want 3ff/1234", mem_addr, mem_wdata);
        end
        step();
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        #1;
        checks++;
        if (cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_norvalid got %b want 0", cpu_rvalid);
        end
        checks++;
        if (vid_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h001) begin
            errors++;
            $display("FAIL wr_vidnext got %b%b %h want 10 001", vid_gnt, mem_we, mem_addr);
        end
        vid_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        doReset();
        vid_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            vid_addr = 10'(10'h100 + c);
            #1;
            checks++;
            if (vid_gnt !== 1'b1 || mem_addr !== 10'(10'h100 + c) || mem_we !== 1'b0) begin
                errors++;
                $display("FAIL b2b_gnt c=%0d got %b %h %b", c, vid_gnt, mem_addr, mem_we);
            end
            step();
            checks++;
            if (vid_rvalid !== 1'b1 || cpu_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_rvalid c=%0d got %b%b want 01", c, cpu_rvalid, vid_rvalid);
            end
        end
        vid_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_read();
        doReset();
        vid_req = 1'b1;
        vid_addr = 10'h2C0;
        #1;
        checks++;
        if (vid_gnt !== 1'b1 || mem_addr !== 10'h2C0) begin
            errors++;
            $display("FAIL mid_gnt got %b %h want 1 2c0", vid_gnt, mem_addr);
        end
        step();
        vid_req = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (vid_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_drop got %b want 0", vid_rvalid);
        end
        rst = 1'b1;
        step();
        checks++;
        if (vid_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_after got %b%b want 00", cpu_rvalid, vid_rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_arbitration();
        test_write_vs_vid();
        test_back_to_back();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
